// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - sweep request/result bus and logic-block stimulus/response signals
//
// master: requester plus the logic block under test (drives start, expected, dut_out)
// slave : the sweeper (drives dut_in, busy, done, pass, table_out, fail_count, first_fail_idx)
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    logic                   start;
    logic [(1<<N_IN)-1:0]   expected;
    logic [N_IN-1:0]        dut_in;
    logic                   dut_out;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(1<<N_IN)-1:0]   table_out;
    logic [N_IN:0]          fail_count;
    logic [N_IN-1:0]        first_fail_idx;

    modport master (
        output start, expected, dut_out,
        input  dut_in, busy, done, pass, table_out, fail_count, first_fail_idx
    );

    modport slave (
        input  start, expected, dut_out,
        output dut_in, busy, done, pass, table_out, fail_count, first_fail_idx
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - handshaked exhaustive truth-table sweep and compare for a small logic block
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of truth_table_sweeper_if:
//           start/expected in, dut_in out to the block, dut_out back from it,
//           busy/done status, pass/table_out/fail_count/first_fail_idx results
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam int              TW       = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TW - 1);
    localparam logic [3:0]      RELOAD   = 4'(SETTLE - 1);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
            $error("truth_table_sweeper: SETTLE=%0d is outside the legal range 1..15", SETTLE);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx;
    logic [3:0]      cnt;
    logic [TW-1:0]   exp_q;
    logic            accept;
    logic            sample_now;
    logic            mismatch;
    logic [N_IN:0]   fail_nxt;

    assign mismatch = (bus.dut_out != exp_q[idx]);
    assign fail_nxt = bus.fail_count + (N_IN+1)'(mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The vector is only presented while HOLD/SAMPLE own it; idx changes on
    // the SAMPLE->HOLD edge, so the block sees one stable vector per window.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        sample_now = 1'b0;
        bus.dut_in = '0;
        bus.busy   = 1'b1;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                bus.dut_in = idx;
                if (cnt == 4'd0) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                bus.dut_in = idx;
                sample_now = 1'b1;
                state_nxt  = (idx == LAST_IDX) ? DONE : HOLD;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx                <= '0;
            cnt                <= 4'd0;
            exp_q              <= '0;
            bus.table_out      <= '0;
            bus.fail_count     <= '0;
            bus.first_fail_idx <= '0;
            bus.pass           <= 1'b0;
        end else if (accept) begin
            idx                <= '0;
            cnt                <= RELOAD;
            exp_q              <= bus.expected;
            bus.table_out      <= '0;
            bus.fail_count     <= '0;
            bus.first_fail_idx <= '0;
            bus.pass           <= 1'b0;
        end else if (state == HOLD && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end else if (sample_now) begin
            bus.table_out[idx] <= bus.dut_out;
            if (mismatch) begin
                bus.fail_count <= fail_nxt;
                // fail_count still zero means this is the first mismatch
                if (bus.fail_count == '0) begin
                    bus.first_fail_idx <= idx;
                end
            end
            if (idx == LAST_IDX) begin
                // verdict includes the sample being taken this edge
                bus.pass <= (fail_nxt == '0);
            end else begin
                idx <= idx + N_IN'(1);
                cnt <= RELOAD;
            end
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;
    logic clk;
    logic rst_n;
    logic tie_one;
    int   n_checks;
    int   n_fail;

    truth_table_sweeper_if #(.N_IN(3)) bus1 ();
    truth_table_sweeper_if #(.N_IN(3)) bus3 ();

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    truth_table_sweeper #(.N_IN(3), .SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    function automatic logic ref_fn(input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return (a | (b & c)) & ((a | c) & b);
    endfunction

    assign bus1.dut_out = tie_one ? 1'b1 : ref_fn(bus1.dut_in);
    assign bus3.dut_out = ref_fn(bus3.dut_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on dut1, then follow the sweep cycle by cycle checking the
    // vector staircase; expected is scrambled after acceptance on purpose.
    task automatic sweep1(input logic [7:0] mask, input string tag);
        int lat;
        int step_err;
        bit seen;
        lat = -1;
        step_err = 0;
        seen = 1'b0;
        bus1.expected = mask;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.expected = ~mask;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (bus1.done === 1'b1) begin
                seen = 1'b1;
                lat = c;
            end else begin
                if (c < 16 && (bus1.dut_in !== 3'(c / 2) || bus1.busy !== 1'b1)) step_err++;
                @(negedge clk);
            end
        end
        chk({tag, "_done_latency"}, 32'(lat), 32'd16);
        chk({tag, "_steps"}, 32'(step_err), 32'd0);
        chk({tag, "_busy_in_done"}, 32'(bus1.busy), 32'd1);
        chk({tag, "_dut_in_in_done"}, 32'(bus1.dut_in), 32'd0);
    endtask

    initial begin
        int dones;
        int lat;
        int step_err;
        int d0;
        int d1;
        bit seen;

        n_checks = 0;
        n_fail = 0;
        tie_one = 1'b0;
        rst_n = 1'b0;
        bus1.start = 1'b0;
        bus1.expected = '0;
        bus3.start = 1'b0;
        bus3.expected = '0;

        // reset state
        @(negedge clk);
        chk("rst_dut_in", 32'(bus1.dut_in), 32'd0);
        chk("rst_busy", 32'(bus1.busy), 32'd0);
        chk("rst_done", 32'(bus1.done), 32'd0);
        chk("rst_pass", 32'(bus1.pass), 32'd0);
        chk("rst_table", 32'(bus1.table_out), 32'd0);
        chk("rst_fail_count", 32'(bus1.fail_count), 32'd0);
        chk("rst_first_fail", 32'(bus1.first_fail_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // matching sweep
        sweep1(8'hC8, "match");
        chk("match_table", 32'(bus1.table_out), 32'hC8);
        chk("match_pass", 32'(bus1.pass), 32'd1);
        chk("match_fail_count", 32'(bus1.fail_count), 32'd0);
        @(negedge clk);
        chk("match_idle_busy", 32'(bus1.busy), 32'd0);
        chk("match_idle_done", 32'(bus1.done), 32'd0);
        chk("match_hold_table", 32'(bus1.table_out), 32'hC8);
        chk("match_hold_pass", 32'(bus1.pass), 32'd1);

        // single mismatch at index 0
        sweep1(8'hC9, "one_miss");
        chk("one_miss_table", 32'(bus1.table_out), 32'hC8);
        chk("one_miss_pass", 32'(bus1.pass), 32'd0);
        chk("one_miss_fail_count", 32'(bus1.fail_count), 32'd1);
        chk("one_miss_first_fail", 32'(bus1.first_fail_idx), 32'd0);
        @(negedge clk);

        // every vector mismatches: fail_count reaches 2**N_IN without wrapping
        tie_one = 1'b1;
        sweep1(8'h00, "all_miss");
        chk("all_miss_table", 32'(bus1.table_out), 32'hFF);
        chk("all_miss_fail_count", 32'(bus1.fail_count), 32'd8);
        chk("all_miss_first_fail", 32'(bus1.first_fail_idx), 32'd0);
        chk("all_miss_pass", 32'(bus1.pass), 32'd0);
        tie_one = 1'b0;
        @(negedge clk);

        // SETTLE=3 instance with extra start pulses while busy
        dones = 0;
        lat = -1;
        step_err = 0;
        bus3.expected = 8'hC8;
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus3.done === 1'b1) begin
                dones++;
                if (lat < 0) lat = c;
            end
            if (c < 32 && (bus3.dut_in !== 3'(c / 4) || bus3.busy !== 1'b1)) step_err++;
            bus3.start = (c == 5 || c == 10 || c == 20 || c == 31) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        bus3.start = 1'b0;
        chk("settle3_done_latency", 32'(lat), 32'd32);
        chk("settle3_done_count", 32'(dones), 32'd1);
        chk("settle3_steps", 32'(step_err), 32'd0);
        chk("settle3_table", 32'(bus3.table_out), 32'hC8);
        chk("settle3_pass", 32'(bus3.pass), 32'd1);

        // reset in the middle of a sweep
        bus1.expected = 8'hC8;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (bus1.dut_in === 3'd4) seen = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reached_vec4", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_dut_in", 32'(bus1.dut_in), 32'd0);
        chk("abort_busy", 32'(bus1.busy), 32'd0);
        chk("abort_table", 32'(bus1.table_out), 32'd0);
        chk("abort_fail_count", 32'(bus1.fail_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        sweep1(8'hC8, "after_abort");
        chk("after_abort_table", 32'(bus1.table_out), 32'hC8);
        chk("after_abort_pass", 32'(bus1.pass), 32'd1);
        @(negedge clk);

        // start held high: back-to-back sweeps with one idle cycle between
        dones = 0;
        d0 = -1;
        d1 = -1;
        step_err = 0;
        bus1.expected = 8'hC8;
        bus1.start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) begin
                dones++;
                if (d0 < 0) d0 = c;
                else if (d1 < 0) d1 = c;
                if (bus1.table_out !== 8'hC8 || bus1.pass !== 1'b1) step_err++;
            end
        end
        bus1.start = 1'b0;
        chk("b2b_done_count", 32'(dones), 32'd2);
        chk("b2b_first_done", 32'(d0), 32'd16);
        chk("b2b_spacing", 32'(d1 - d0), 32'd18);
        chk("b2b_results", 32'(step_err), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) seen = 1'b1;
        end
        chk("b2b_third_drains", 32'(seen), 32'd1);
        chk("b2b_third_table", 32'(bus1.table_out), 32'hC8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
